// File: rtl/tag_array_pkg.sv
// Shared sizes, entry layout and state encoding for the tag SRAM controller.
package tag_array_pkg;

   localparam int SETS    = 64;
   localparam int WAYS    = 8;
   localparam int ENTRY_W = 23;
   localparam int IDX_W   = $clog2(SETS);
   localparam int WAY_W   = $clog2(WAYS);
   localparam int TAG_W   = ENTRY_W - 1;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
   } tag_entry_t;

   typedef enum logic {
      SWEEP = 1'b0,
      RUN   = 1'b1
   } ctrl_state_t;

   // Isolates the least-significant set bit (two's-complement trick).
   function automatic logic [WAYS-1:0] onehot_lowest(input logic [WAYS-1:0] vec);
      return vec & (~vec + WAYS'(1));
   endfunction

endpackage

// File: rtl/tag_way_compare.sv
// Combinational compare of one SRAM row (all ways) against a lookup tag.
module tag_way_compare
   import tag_array_pkg::*;
(
   input  logic [WAYS*ENTRY_W-1:0] entries,
   input  logic [TAG_W-1:0]        tag,
   output logic [WAYS-1:0]         match_lowest,
   output logic                    hit,
   output logic                    multi
);

   logic [WAYS-1:0] match;

   for (genvar i = 0; i < WAYS; i++) begin : g_way
      tag_entry_t ent;
      assign ent      = entries[i*ENTRY_W +: ENTRY_W];
      assign match[i] = ent.valid && (ent.tag == tag);
   end

   assign match_lowest = onehot_lowest(match);
   assign hit          = |match;
   // Clearing the lowest set bit leaves something only if two or more ways matched.
   assign multi        = (match & (match - WAYS'(1))) != '0;

endmodule

// File: rtl/tag_array_ctrl.sv
// Arbitrates the tag SRAM between lookups and updates, and clears it after reset/flush.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   SWEEP | writing zeros to every set, one set per cycle; busy high
//   RUN   | serving flush > update > lookup; readies high
module tag_array_ctrl
   import tag_array_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    flush_req,
   output logic                    busy,
   output logic                    flush_done,
   input  logic                    lk_valid,
   output logic                    lk_ready,
   input  logic [IDX_W-1:0]        lk_idx,
   input  logic [TAG_W-1:0]        lk_tag,
   output logic                    rsp_valid,
   output logic                    rsp_hit,
   output logic [WAYS-1:0]         rsp_way,
   output logic                    rsp_multi,
   input  logic                    up_valid,
   output logic                    up_ready,
   input  logic [IDX_W-1:0]        up_idx,
   input  logic [WAY_W-1:0]        up_way,
   input  logic [ENTRY_W-1:0]      up_entry,
   output logic                    sram_r_en,
   output logic [IDX_W-1:0]        sram_r_addr,
   input  logic [WAYS*ENTRY_W-1:0] sram_r_data,
   output logic                    sram_w_en,
   output logic [IDX_W-1:0]        sram_w_addr,
   output logic [WAYS*ENTRY_W-1:0] sram_w_data,
   output logic [WAYS-1:0]         sram_w_mask
);

   ctrl_state_t       state;
   logic [IDX_W-1:0]  sweep_cnt;
   logic [IDX_W-1:0]  r_addr_q;
   logic [IDX_W-1:0]  w_addr_q;
   logic [TAG_W-1:0]  tag_q;
   logic              rsp_pend_q;

   logic              sweeping;
   logic              run_ok;
   logic              up_acc;
   logic              lk_acc;
   logic [WAYS-1:0]   cmp_lowest;
   logic              cmp_hit;
   logic              cmp_multi;

   // Sweep writes are gated by reset so the SRAM sees no write while reset is held.
   assign sweeping = (state == SWEEP) && reset_n;
   assign run_ok   = (state == RUN) && !flush_req;
   assign busy     = (state == SWEEP);
   assign up_ready = run_ok;
   assign lk_ready = run_ok && !(up_valid && (up_idx == lk_idx));
   assign up_acc   = up_valid && up_ready;
   assign lk_acc   = lk_valid && lk_ready;

   always_comb begin
      sram_w_en   = 1'b0;
      sram_w_addr = w_addr_q;
      sram_w_data = '0;
      sram_w_mask = '0;
      if (sweeping) begin
         sram_w_en   = 1'b1;
         sram_w_addr = sweep_cnt;
         sram_w_mask = '1;
      end else if (up_acc) begin
         sram_w_en   = 1'b1;
         sram_w_addr = up_idx;
         sram_w_data = {WAYS{up_entry}};
         sram_w_mask = WAYS'(1) << up_way;
      end
   end

   assign sram_r_en   = lk_acc;
   assign sram_r_addr = lk_acc ? lk_idx : r_addr_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= SWEEP;
         sweep_cnt  <= '0;
         flush_done <= 1'b0;
      end else begin
         flush_done <= 1'b0;
         case (state)
            SWEEP: begin
               sweep_cnt <= sweep_cnt + IDX_W'(1);
               if (sweep_cnt == IDX_W'(SETS - 1)) begin
                  state      <= RUN;
                  flush_done <= 1'b1;
               end
            end
            RUN: begin
               if (flush_req) begin
                  state     <= SWEEP;
                  sweep_cnt <= '0;
               end
            end
            default: state <= SWEEP;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_addr_q   <= '0;
         w_addr_q   <= '0;
         tag_q      <= '0;
         rsp_pend_q <= 1'b0;
      end else begin
         rsp_pend_q <= lk_acc;
         if (lk_acc) begin
            r_addr_q <= lk_idx;
            tag_q    <= lk_tag;
         end
         if (sram_w_en) w_addr_q <= sram_w_addr;
      end
   end

   // Compare sits behind the response register: read data arrives the cycle after the request.
   tag_way_compare u_cmp (
      .entries      (sram_r_data),
      .tag          (tag_q),
      .match_lowest (cmp_lowest),
      .hit          (cmp_hit),
      .multi        (cmp_multi)
   );

   assign rsp_valid = rsp_pend_q;
   assign rsp_hit   = rsp_pend_q && cmp_hit;
   assign rsp_way   = rsp_pend_q ? cmp_lowest : '0;
   assign rsp_multi = rsp_pend_q && cmp_multi;

endmodule
